uart_rx_deframer: RTL and testbench

//  Receive side of the UART link. Samples the asynchronous serial line and

---
 rtl/uart_rx_deframer_if.sv | 19 +
 rtl/uart_rx_deframer.sv | 126 ++++++++++++
 tb/tb_uart_rx_deframer.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deframer_if.sv
// Line-side input and byte-side outputs of the UART receiver.
// The deframer takes the master view; the line driver and byte consumer take the slave view.
interface uart_rx_deframer_if;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  rx_in,
    output data_out, data_valid, frame_err, busy
  );

  modport slave (
    output rx_in,
    input  data_out, data_valid, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 8N1 frames, LSB first, mid-bit sampling of a synchronised line.
// Emits each good byte with a one-cycle strobe and flags a bad stop bit.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clk,
  input  logic               arst_n,
  uart_rx_deframer_if.master rx_bus
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t           state;
  logic             rx_p0;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       data_q;
  logic             data_valid_q;
  logic             frame_err_q;
  logic             busy_q;

  // Two-flop synchroniser; reset to the idle (high) line level
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx_bus.rx_in;
      rx_s  <= rx_p0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      cnt          <= cnt + 1'b1;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          // A start bit that is already high again at its midpoint was a glitch
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        DATA: begin
          if (cnt == FULL_LAST) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (cnt == FULL_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              data_q       <= shift_reg;
              data_valid_q <= 1'b1;
              state        <= IDLE;
              busy_q       <= 1'b0;
            end else begin
              frame_err_q <= 1'b1;
              state       <= WAIT_HI;
            end
          end
        end
        WAIT_HI: begin
          // A held-low (break) line must go high before a new start can be seen
          cnt <= '0;
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          cnt    <= '0;
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_bus.data_out   = data_q;
  assign rx_bus.data_valid = data_valid_q;
  assign rx_bus.frame_err  = frame_err_q;
  assign rx_bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: line waveforms are built per cycle, a sample-point
// model predicts each strobe, and one compare process checks the outputs every cycle.
module tb_uart_rx_deframer;
  localparam int CPB     = 16;
  localparam int HALF    = CPB / 2;
  localparam int LAT_MIN = 9 * CPB + HALF + 2;
  localparam int LAT_MAX = LAT_MIN + 2;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;

  uart_rx_deframer_if bus ();

  uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .rx_bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [7:0] val;
    int         start_cyc;
  } ev_t;

  ev_t        exp_q[$];
  bit         wave[$];
  logic [7:0] model_data = 8'h00;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_valid = 0;
  int         n_err   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
    end
  endtask

  task automatic add_bits(input bit v, input int n);
    for (int k = 0; k < n; k++) wave.push_back(v);
  endtask

  task automatic add_frame(input logic [7:0] b, input int p, input bit stop);
    add_bits(1'b0, p);
    for (int k = 0; k < 8; k++) add_bits(b[k], p);
    add_bits(stop, p);
  endtask

  // Receiver view of a waveform: after a falling edge at index i the line is
  // looked at i+HALF (start), i+HALF+CPB*k (data k-1), i+HALF+9*CPB (stop).
  task automatic model_frames(input int base);
    int         i;
    int         h;
    logic [7:0] b;
    ev_t        ev;
    i = 0;
    while (i < wave.size()) begin
      if (wave[i]) begin
        i++;
      end else if (i + HALF >= wave.size()) begin
        i = wave.size();
      end else if (wave[i+HALF]) begin
        i = i + HALF + 1;
      end else if (i + HALF + 9 * CPB >= wave.size()) begin
        i = wave.size();
      end else begin
        for (int k = 0; k < 8; k++) b[k] = wave[i + HALF + CPB * (k + 1)];
        ev.is_err    = !wave[i + HALF + 9 * CPB];
        ev.val       = b;
        ev.start_cyc = base + i;
        exp_q.push_back(ev);
        if (!ev.is_err) begin
          i = i + HALF + 9 * CPB + 1;
        end else begin
          h = i + HALF + 9 * CPB + 1;
          while (h < wave.size() && !wave[h]) h++;
          i = h + 1;
        end
      end
    end
  endtask

  task automatic play();
    int base;
    @(negedge clk);
    base = cyc;
    model_frames(base);
    foreach (wave[n]) begin
      if (n != 0) @(negedge clk);
      bus.rx_in = wave[n];
    end
    @(negedge clk);
    wave.delete();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d strobes still outstanding, 0 required", exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  ev_t cur;
  int  lat;
  bit  prev_dv = 1'b0;
  bit  prev_fe = 1'b0;

  always @(negedge clk) begin
    if (arst_n) begin
      if (bus.data_valid || bus.frame_err) begin
        check("strobe_exclusive", 32'(bus.data_valid & bus.frame_err), 0);
        check("strobe_one_cycle", 32'((bus.data_valid & prev_dv) | (bus.frame_err & prev_fe)), 0);
        if (bus.data_valid) n_valid++;
        if (bus.frame_err)  n_err++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_strobe: data_valid=%0d frame_err=%0d data_out=%0h, no strobe required",
                   bus.data_valid, bus.frame_err, bus.data_out);
        end else begin
          cur = exp_q.pop_front();
          lat = cyc - cur.start_cyc;
          check("strobe_kind_frame_err", 32'(bus.frame_err), 32'(cur.is_err));
          n_tests++;
          if (lat < LAT_MIN || lat > LAT_MAX) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles, required %0d..%0d", lat, LAT_MIN, LAT_MAX);
          end
          if (!cur.is_err) begin
            check("data_out_new", 32'(bus.data_out), 32'(cur.val));
            model_data = cur.val;
          end else begin
            check("data_out_held_on_err", 32'(bus.data_out), 32'(model_data));
          end
        end
      end else begin
        check("data_out_stable", 32'(bus.data_out), 32'(model_data));
      end
    end
    prev_dv = bus.data_valid;
    prev_fe = bus.frame_err;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog expired");
  end

  int  v0;
  int  e0;
  bit  saw_busy;
  bit  released;

  initial begin
    bus.rx_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data_out",   32'(bus.data_out),   0);
    check("reset_data_valid", 32'(bus.data_valid), 0);
    check("reset_frame_err",  32'(bus.frame_err),  0);
    check("reset_busy",       32'(bus.busy),       0);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single frame
    add_bits(1'b1, 8);
    add_frame(8'hA5, CPB, 1'b1);
    add_bits(1'b1, 20);
    play();
    drain();
    check("t1_data_out", 32'(bus.data_out), 'hA5);
    check("t1_busy_after", 32'(bus.busy), 0);
    check("t1_valid_count", n_valid, 1);

    // Back-to-back frames, no idle gap
    v0 = n_valid;
    add_bits(1'b1, 4);
    add_frame(8'h00, CPB, 1'b1);
    add_frame(8'hFF, CPB, 1'b1);
    add_frame(8'h3C, CPB, 1'b1);
    add_bits(1'b1, 20);
    play();
    drain();
    check("t2_data_out", 32'(bus.data_out), 'h3C);
    check("t2_valid_count", n_valid - v0, 3);

    // Short glitch on the line
    v0 = n_valid;
    e0 = n_err;
    saw_busy = 1'b0;
    released = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      bus.rx_in = 1'b0;
      if (bus.busy) saw_busy = 1'b1;
    end
    for (int n = 0; n < 16 && !released; n++) begin
      @(negedge clk);
      bus.rx_in = 1'b1;
      if (bus.busy) saw_busy = 1'b1;
      else if (saw_busy) released = 1'b1;
    end
    repeat (40) @(negedge clk);
    check("t3_busy_seen", 32'(saw_busy), 1);
    check("t3_busy_released", 32'(released), 1);
    check("t3_no_strobes", (n_valid - v0) + (n_err - e0), 0);

    // Bad stop bit, long break, then a good frame
    v0 = n_valid;
    e0 = n_err;
    add_bits(1'b1, 4);
    add_frame(8'h55, CPB, 1'b0);
    add_bits(1'b0, 20 * CPB);
    add_bits(1'b1, 2 * CPB);
    add_frame(8'h81, CPB, 1'b1);
    add_bits(1'b1, 20);
    play();
    drain();
    check("t4_err_count", n_err - e0, 1);
    check("t4_valid_count", n_valid - v0, 1);
    check("t4_data_out", 32'(bus.data_out), 'h81);

    // Reset in the middle of bit 4 of 0xC3
    v0 = n_valid;
    add_bits(1'b1, 4);
    add_bits(1'b0, CPB);
    for (int k = 0; k < 4; k++) add_bits(((8'hC3 >> k) & 8'h01) != 0, CPB);
    add_bits(1'b0, HALF);
    play();
    arst_n = 1'b0;
    model_data = 8'h00;
    exp_q.delete();
    bus.rx_in = 1'b1;
    @(negedge clk);
    check("t5_rst_data_out",   32'(bus.data_out),   0);
    check("t5_rst_data_valid", 32'(bus.data_valid), 0);
    check("t5_rst_frame_err",  32'(bus.frame_err),  0);
    check("t5_rst_busy",       32'(bus.busy),       0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
    add_bits(1'b1, 8);
    add_frame(8'h7E, CPB, 1'b1);
    add_bits(1'b1, 20);
    play();
    drain();
    check("t5_valid_count", n_valid - v0, 1);
    check("t5_data_out", 32'(bus.data_out), 'h7E);

    // Skewed bit rates: at 15-cycle bits the 1-cycle/bit drift moves the D6
    // sample into D7, so the byte seen is whatever the sample points land on.
    add_bits(1'b1, 4);
    add_frame(8'h96, 15, 1'b1);
    add_bits(1'b1, 20);
    play();
    drain();
    add_bits(1'b1, 4);
    add_frame(8'h96, 17, 1'b1);
    add_bits(1'b1, 20);
    play();
    drain();
    check("t6_skew17_data_out", 32'(bus.data_out), 'h96);
    check("t6_busy_after", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
